// File: rtl/prog_tick_timer_if.sv
// Bundle of configuration, control and status signals for prog_tick_timer.
// The master drives writes and per-channel requests; the slave (the timer) returns status.
interface prog_tick_timer_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 26
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_period;
  logic             wr_mode;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   stop;
  logic [NCH-1:0]   done_clr;
  logic [CHW-1:0]   rd_ch;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;
  logic [WIDTH-1:0] rd_count;

  modport master (
    output wr_en, wr_ch, wr_period, wr_mode, start, stop, done_clr, rd_ch,
    input  tick, busy, done, rd_count
  );

  modport slave (
    input  wr_en, wr_ch, wr_period, wr_mode, start, stop, done_clr, rd_ch,
    output tick, busy, done, rd_count
  );
endinterface

// File: rtl/prog_tick_timer.sv
// Multi-channel programmable down-counting tick timer, periodic or one-shot per channel,
// with sticky one-shot completion flags and a muxed count readback.
module prog_tick_timer #(
  parameter int          NCH            = 4,
  parameter int          WIDTH          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic            clk,
  input  logic            resetn,
  prog_tick_timer_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state  [NCH];
  logic [WIDTH-1:0] period [NCH];
  logic [WIDTH-1:0] count  [NCH];
  logic [NCH-1:0]   mode;
  logic [NCH-1:0]   done;

  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   mode_sel;
  logic [WIDTH-1:0] load_val [NCH];
  logic [NCH-1:0]   expire;
  logic [NCH-1:0]   done_set;
  logic [NCH-1:0]   done_clear;
  logic [NCH-1:0]   tick_v;
  logic [NCH-1:0]   busy_v;
  logic [WIDTH-1:0] rd_v;

  // A zero period behaves as one, so the reload value saturates at zero.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] p);
    return (p == '0) ? '0 : p - WIDTH'(1);
  endfunction

  always_comb begin
    wr_hit     = '0;
    mode_sel   = '0;
    expire     = '0;
    done_set   = '0;
    done_clear = '0;
    tick_v     = '0;
    busy_v     = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      load_val[ch] = '0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      // Out-of-range channel numbers never match, so such writes fall away.
      wr_hit[ch]   = bus.wr_en && (bus.wr_ch == CHW'(ch));
      mode_sel[ch] = wr_hit[ch] ? bus.wr_mode : mode[ch];
      load_val[ch] = sat_load(wr_hit[ch] ? bus.wr_period : period[ch]);
      busy_v[ch]   = (state[ch] == RUN);
      expire[ch]   = busy_v[ch] && (count[ch] == '0);
      tick_v[ch]   = expire[ch];
      done_set[ch] = expire[ch] && mode_sel[ch] && !bus.stop[ch] && !bus.start[ch];
      done_clear[ch] = bus.done_clr[ch] ||
                       ((state[ch] == IDLE) && bus.start[ch] && !bus.stop[ch]);
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (!resetn) begin
        period[ch] <= WIDTH'(DEFAULT_PERIOD);
        mode[ch]   <= 1'b0;
        state[ch]  <= IDLE;
        count[ch]  <= '0;
        done[ch]   <= 1'b0;
      end else begin
        if (wr_hit[ch]) begin
          period[ch] <= bus.wr_period;
          mode[ch]   <= bus.wr_mode;
        end

        // stop beats start, start beats the free-running count behaviour.
        if (bus.stop[ch]) begin
          state[ch] <= IDLE;
          count[ch] <= '0;
        end else if (bus.start[ch]) begin
          state[ch] <= RUN;
          count[ch] <= load_val[ch];
        end else if (state[ch] == RUN) begin
          if (count[ch] == '0) begin
            if (mode_sel[ch]) begin
              state[ch] <= IDLE;
            end else begin
              count[ch] <= load_val[ch];
            end
          end else begin
            count[ch] <= count[ch] - WIDTH'(1);
          end
        end

        if (done_set[ch]) begin
          done[ch] <= 1'b1;
        end else if (done_clear[ch]) begin
          done[ch] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_v = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (bus.rd_ch == CHW'(ch)) begin
        rd_v = count[ch];
      end
    end
  end

  assign bus.tick     = tick_v;
  assign bus.busy     = busy_v;
  assign bus.done     = done;
  assign bus.rd_count = rd_v;

endmodule

// File: tb/tb_prog_tick_timer.sv
// Directed bench for prog_tick_timer: a per-cycle vector table plus hand sequences
// for reset, default period and out-of-range channel behaviour.
module tb_prog_tick_timer;
  logic clk;
  logic resetn;

  prog_tick_timer_if #(.NCH(4), .WIDTH(26)) bus ();
  prog_tick_timer_if #(.NCH(3), .WIDTH(8))  bus3 ();

  prog_tick_timer #(.NCH(4), .WIDTH(26), .DEFAULT_PERIOD(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  prog_tick_timer #(.NCH(3), .WIDTH(8), .DEFAULT_PERIOD(5)) dut3 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  st, sp, dc;
    logic        we;
    logic [1:0]  wch;
    logic [25:0] wp;
    logic        wm;
    logic [1:0]  rch;
    logic [3:0]  tk, bz, dn;
    logic [25:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t wv(logic [3:0] st, logic [3:0] sp, logic [3:0] dc,
                              logic [1:0] wch, logic [25:0] wp, logic wm, logic [1:0] rch,
                              logic [3:0] tk, logic [3:0] bz, logic [3:0] dn, logic [25:0] cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.dc = dc; v.we = 1'b1; v.wch = wch; v.wp = wp; v.wm = wm;
    v.rch = rch; v.tk = tk; v.bz = bz; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t nv(logic [3:0] st, logic [3:0] sp, logic [3:0] dc, logic [1:0] rch,
                              logic [3:0] tk, logic [3:0] bz, logic [3:0] dn, logic [25:0] cnt);
    vec_t v;
    v = wv(st, sp, dc, 2'd0, 26'd0, 1'b0, rch, tk, bz, dn, cnt);
    v.we = 1'b0;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_period = '0; bus.wr_mode = 1'b0;
    bus.start = '0; bus.stop = '0; bus.done_clr = '0; bus.rd_ch = '0;
    bus3.wr_en = 1'b0; bus3.wr_ch = '0; bus3.wr_period = '0; bus3.wr_mode = 1'b0;
    bus3.start = '0; bus3.stop = '0; bus3.done_clr = '0; bus3.rd_ch = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bus.start = v.st; bus.stop = v.sp; bus.done_clr = v.dc;
    bus.wr_en = v.we; bus.wr_ch = v.wch; bus.wr_period = v.wp; bus.wr_mode = v.wm;
    bus.rd_ch = v.rch;
    #1;
    check($sformatf("vec%0d tick", idx),     32'(bus.tick),     32'(v.tk));
    check($sformatf("vec%0d busy", idx),     32'(bus.busy),     32'(v.bz));
    check($sformatf("vec%0d done", idx),     32'(bus.done),     32'(v.dn));
    check($sformatf("vec%0d rd_count", idx), 32'(bus.rd_count), 32'(v.cnt));
    cyc();
  endtask

  initial begin
    int n;
    // Channel 0, P=4 periodic, write and start together: ticks at cycles 4, 8, 12.
    tbl.push_back(wv(4'h1,4'h0,4'h0, 2'd0,26'd4,1'b0, 2'd0, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd3));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h1,4'h1,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd3));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h1,4'h1,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd3));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h1,4'h1,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h1,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd3));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h0,4'h0,26'd0));
    // Channel 1, P=3 one-shot: single tick, sticky done, clear, expiry+clear, stop+start.
    tbl.push_back(wv(4'h0,4'h0,4'h0, 2'd1,26'd3,1'b1, 2'd1, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h2,4'h0,4'h0,2'd1, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h2,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h2,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h2,4'h2,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h0,4'h2,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h2,2'd1, 4'h0,4'h0,4'h2,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h2,4'h0,4'h0,2'd1, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h2,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h2,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h2,2'd1, 4'h2,4'h2,4'h0,26'd0));
    tbl.push_back(nv(4'h2,4'h0,4'h0,2'd1, 4'h0,4'h0,4'h2,26'd0));
    tbl.push_back(nv(4'h2,4'h2,4'h0,2'd1, 4'h0,4'h2,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd1, 4'h0,4'h0,4'h0,26'd0));
    // Channel 2, P=0 then P=1 periodic: tick every cycle, stop kills it next cycle.
    tbl.push_back(wv(4'h4,4'h0,4'h0, 2'd2,26'd0,1'b0, 2'd2, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd2, 4'h4,4'h4,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd2, 4'h4,4'h4,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h4,4'h0,2'd2, 4'h4,4'h4,4'h0,26'd0));
    tbl.push_back(wv(4'h4,4'h0,4'h0, 2'd2,26'd1,1'b0, 2'd2, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd2, 4'h4,4'h4,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h4,4'h0,2'd2, 4'h4,4'h4,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd2, 4'h0,4'h0,4'h0,26'd0));
    // Channel 0, P=10 running, rewrite P=2 at count 5: interval completes, then every 2.
    tbl.push_back(wv(4'h1,4'h0,4'h0, 2'd0,26'd10,1'b0, 2'd0, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd9));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd8));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd7));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd6));
    tbl.push_back(wv(4'h0,4'h0,4'h0, 2'd0,26'd2,1'b0, 2'd0, 4'h0,4'h1,4'h0,26'd5));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd4));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd3));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h1,4'h1,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h1,4'h1,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h1,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h1,4'h0,2'd0, 4'h1,4'h1,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd0, 4'h0,4'h0,4'h0,26'd0));
    // Channel 3, P=3 one-shot: restart exactly at count 0 gives tick and reload, no done.
    tbl.push_back(wv(4'h8,4'h0,4'h0, 2'd3,26'd3,1'b1, 2'd3, 4'h0,4'h0,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd3, 4'h0,4'h8,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd3, 4'h0,4'h8,4'h0,26'd1));
    tbl.push_back(nv(4'h8,4'h0,4'h0,2'd3, 4'h8,4'h8,4'h0,26'd0));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd3, 4'h0,4'h8,4'h0,26'd2));
    tbl.push_back(nv(4'h0,4'h8,4'h0,2'd3, 4'h0,4'h8,4'h0,26'd1));
    tbl.push_back(nv(4'h0,4'h0,4'h0,2'd3, 4'h0,4'h0,4'h0,26'd0));

    // Reset with busy inputs; state must come up cleared.
    clear_in();
    resetn = 1'b0;
    bus.start = 4'hF;
    bus.wr_en = 1'b1;
    bus.wr_period = 26'd2;
    repeat (2) cyc();
    check("reset tick",     32'(bus.tick),     32'd0);
    check("reset busy",     32'(bus.busy),     32'd0);
    check("reset done",     32'(bus.done),     32'd0);
    check("reset rd_count", 32'(bus.rd_count), 32'd0);
    clear_in();
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], i);
    end

    // All four channels running, then a reset pulse.
    clear_in();
    bus.start = 4'hF;
    cyc();
    bus.start = 4'h0;
    #1;
    check("allrun busy", 32'(bus.busy), 32'hF);
    cyc();
    resetn = 1'b0;
    bus.start = 4'hF;
    bus.wr_en = 1'b1;
    bus.wr_ch = 2'd3;
    bus.wr_period = 26'd2;
    cyc();
    check("midreset tick", 32'(bus.tick), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      bus.rd_ch = 2'(c);
      #1;
      check($sformatf("midreset rd_count ch%0d", c), 32'(bus.rd_count), 32'd0);
    end
    clear_in();
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check($sformatf("postreset quiet %0d", k), 32'({bus.tick, bus.busy}), 32'd0);
    end

    // Channel 3 restarts from the reset period (6) after the rewrite was overridden.
    bus.rd_ch = 2'd3;
    bus.start = 4'h8;
    cyc();
    bus.start = 4'h0;
    #1;
    check("default period load", 32'(bus.rd_count), 32'd5);
    check("default period busy", 32'(bus.busy), 32'h8);
    n = 1;
    while (n < 20 && !bus.tick[3]) begin
      cyc();
      n++;
    end
    check("default period tick latency", n, 32'd6);
    bus.stop = 4'hF;
    cyc();
    bus.stop = 4'h0;

    // Three-channel instance: writes and reads of channel 3 are out of range.
    bus3.wr_en = 1'b1;
    bus3.wr_ch = 2'd3;
    bus3.wr_period = 8'd2;
    bus3.wr_mode = 1'b1;
    cyc();
    bus3.wr_en = 1'b0;
    bus3.start = 3'b111;
    cyc();
    bus3.start = 3'b000;
    #1;
    check("nch3 busy", 32'(bus3.busy), 32'h7);
    for (int c = 0; c < 3; c++) begin
      bus3.rd_ch = 2'(c);
      #1;
      check($sformatf("nch3 rd_count ch%0d", c), 32'(bus3.rd_count), 32'd4);
    end
    bus3.rd_ch = 2'd3;
    #1;
    check("nch3 rd_count out of range", 32'(bus3.rd_count), 32'd0);
    repeat (4) cyc();
    check("nch3 tick", 32'(bus3.tick), 32'h7);
    cyc();
    check("nch3 periodic reload", 32'({bus3.busy, bus3.done}), 32'({3'b111, 3'b000}));
    bus3.stop = 3'b111;
    cyc();
    bus3.stop = 3'b000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_tick_timer.md
PROG_TICK_TIMER -- requirements
Module: prog_tick_timer

Interface
REQ-001 Parameter NCH, default 4, number of independent timer channels (1..16).
REQ-002 Parameter WIDTH, default 26, counter and period width in bits.
REQ-003 Parameter DEFAULT_PERIOD, default 50000000, period loaded into every channel at reset (1 s at 50 MHz).
REQ-004 Derived CHW = max(1, clog2(NCH)), channel-select width.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 wr_en  in  1  configuration write strobe.
REQ-008 wr_ch  in  CHW  channel addressed by the write.
REQ-009 wr_period  in  WIDTH  tick period in clk cycles.
REQ-010 wr_mode  in  1  0 = periodic, 1 = one-shot.
REQ-011 start  in  NCH  per-channel start/restart request, one bit per channel.
REQ-012 stop  in  NCH  per-channel stop request.
REQ-013 done_clr  in  NCH  per-channel clear of the sticky done flag.
REQ-014 rd_ch  in  CHW  channel selected for count readback.
REQ-015 tick  out  NCH  one-cycle pulse per expiry, per channel.
REQ-016 busy  out  NCH  channel in RUN state.
REQ-017 done  out  NCH  sticky one-shot completion flag.
REQ-018 rd_count  out  WIDTH  current count of channel rd_ch.

Function
REQ-019 Each channel SHALL hold period[ch] (WIDTH), mode[ch] (1), count[ch] (WIDTH), a two-state FSM IDLE/RUN, and done[ch].
REQ-020 A write (wr_en=1, wr_ch<NCH) SHALL update period[wr_ch] and mode[wr_ch] at the clock edge; wr_ch>=NCH SHALL be ignored.
REQ-021 A period write SHALL NOT alter a running count; it SHALL take effect at the next load (start or periodic reload).
REQ-022 The effective period SHALL be max(period,1); a period of 0 behaves as 1.
REQ-023 tick[ch] SHALL be combinational: 1 exactly when state=RUN and count=0.
REQ-024 busy[ch] SHALL equal (state=RUN).
REQ-025 Load value SHALL be effective period minus 1, so consecutive periodic ticks are exactly P cycles apart and the first tick occurs P cycles after the start edge.
REQ-026 IDLE + start: load count, go to RUN, clear done[ch].
REQ-027 RUN with count>0: decrement count by 1 per cycle.
REQ-028 RUN with count=0 in periodic mode: reload count and stay in RUN.
REQ-029 RUN with count=0 in one-shot mode: go to IDLE, set done[ch], leave count at 0.
REQ-030 RUN + start: reload count and stay in RUN (restart); done is not set that cycle; tick still reflects the pre-edge count.
REQ-031 stop: go to IDLE and clear count to 0 from either state; done is unchanged; a tick present in the same cycle is still emitted.
REQ-032 Priority per channel SHALL be stop > start > count/reload behaviour.
REQ-033 A write to channel ch and start[ch] in the same cycle SHALL load from the newly written period and mode.
REQ-034 done[ch] set and done_clr[ch] in the same cycle: set wins. done_clr alone clears done.
REQ-035 rd_count SHALL be count[rd_ch] combinationally, and 0 when rd_ch>=NCH.
REQ-036 Channels SHALL be fully independent; simultaneous events on different channels SHALL NOT interact.
REQ-037 The counter SHALL never wrap below 0 or exceed period-1.

Reset
REQ-038 resetn=0 at a clock edge SHALL force: period=DEFAULT_PERIOD, mode=periodic, state=IDLE, count=0, done=0 on all channels.
REQ-039 This gives tick=0, busy=0, done=0, rd_count=0 after reset; reset overrides all inputs in that cycle.
REQ-040 Reset asserted mid-count SHALL abandon the count with no tick; after release the channel stays idle until start.

Verification
REQ-041 Channel 0, period=4, periodic, start at cycle 0 -> tick[0] at cycles 4, 8, 12; busy[0]=1 from cycle 1.
REQ-042 Channel 1, period=3, one-shot, start -> single tick 3 cycles later; next cycle busy[1]=0 and done[1]=1; done_clr[1] -> done[1]=0.
REQ-043 Channel 2, period=0 or 1, periodic -> tick[2] every cycle while running; stop -> tick[2]=0 and rd_count=0 from the next cycle.
REQ-044 Channel 0, period=10, running; write period=2 at count=5 -> the current interval completes at 10 cycles, then ticks every 2 cycles.
REQ-045 Corner cases:
- stop with start on the same channel -> IDLE;
- one-shot expiry with done_clr -> done=1;
- start at count=0 in RUN -> tick pulse plus reload, with no done set.
REQ-046 Reset pulse while all 4 channels run -> all outputs 0 next cycle; rd_count=0 for every rd_ch; no tick until a new start.
